// File: rtl/register_file_8x8_if.sv
// Register file bus: write-back data/strobe, read/output commands and the
// registered operand/output words returned by the register file.
//   master : drives write/read/output commands, samples read data
//   slave  : register file side
interface register_file_8x8_if #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned ADDR_W = 3
);
    logic [WIDTH-1:0]  from_mux;
    logic              write_enable;
    logic [ADDR_W-1:0] write_addr;
    logic              read_enable;
    logic [ADDR_W-1:0] read_a_addr;
    logic [ADDR_W-1:0] read_b_addr;
    logic              output_enable;
    logic [WIDTH-1:0]  read_a_data;
    logic [WIDTH-1:0]  read_b_data;
    logic              read_valid;
    logic [WIDTH-1:0]  output_data;

    modport master (
        output from_mux, write_enable, write_addr,
        output read_enable, read_a_addr, read_b_addr, output_enable,
        input  read_a_data, read_b_data, read_valid, output_data
    );

    modport slave (
        input  from_mux, write_enable, write_addr,
        input  read_enable, read_a_addr, read_b_addr, output_enable,
        output read_a_data, read_b_data, read_valid, output_data
    );
endinterface

// File: rtl/register_file_8x8.sv
// Datapath register file: DEPTH x WIDTH storage written from the write-back
// mux, two registered read ports (A, B) and a held output word loaded from
// the port A source. Reads and output loads see a same-edge write
// (write-through bypass).
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high; clears storage and all outputs
//   bus   : register_file_8x8_if.slave (commands in, read/output data out)
module register_file_8x8 #(
    parameter int unsigned     WIDTH       = 8,
    parameter int unsigned     DEPTH       = 8,
    parameter int unsigned     ADDR_W      = 3,
    parameter logic [WIDTH-1:0] RESET_VALUE = 8'h00
) (
    input  logic                 clk,
    input  logic                 reset,
    register_file_8x8_if.slave   bus
);

    logic [WIDTH-1:0] regs [DEPTH];
    logic [WIDTH-1:0] read_a_q;
    logic [WIDTH-1:0] read_b_q;
    logic             read_valid_q;
    logic [WIDTH-1:0] output_q;

    logic             hit_a_c;
    logic             hit_b_c;
    logic [WIDTH-1:0] value_a_c;
    logic [WIDTH-1:0] value_b_c;

    // Write-through bypass: a same-edge write to the read address wins.
    always_comb begin
        hit_a_c   = 1'b0;
        hit_b_c   = 1'b0;
        value_a_c = regs[bus.read_a_addr];
        value_b_c = regs[bus.read_b_addr];
        if (bus.write_enable) begin
            hit_a_c = (bus.write_addr == bus.read_a_addr);
            hit_b_c = (bus.write_addr == bus.read_b_addr);
        end
        if (hit_a_c) value_a_c = bus.from_mux;
        if (hit_b_c) value_b_c = bus.from_mux;
    end

    // Storage, read ports and output word; reset overrides every command.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                regs[i] <= RESET_VALUE;
            end
            read_a_q     <= RESET_VALUE;
            read_b_q     <= RESET_VALUE;
            read_valid_q <= 1'b0;
            output_q     <= RESET_VALUE;
        end else begin
            if (bus.write_enable) begin
                regs[bus.write_addr] <= bus.from_mux;
            end
            // read_valid is a one-cycle pulse per launched read
            read_valid_q <= bus.read_enable;
            if (bus.read_enable) begin
                read_a_q <= value_a_c;
                read_b_q <= value_b_c;
            end
            if (bus.output_enable) begin
                output_q <= value_a_c;
            end
        end
    end

    assign bus.read_a_data = read_a_q;
    assign bus.read_b_data = read_b_q;
    assign bus.read_valid  = read_valid_q;
    assign bus.output_data = output_q;

endmodule

// File: tb/tb_register_file_8x8.sv
// Table-driven bench for register_file_8x8: each record is one clock edge of
// inputs plus the outputs expected just after that edge.
module tb_register_file_8x8;

    typedef struct {
        logic       rst;
        logic       we;
        logic [2:0] wa;
        logic [7:0] din;
        logic       re;
        logic [2:0] ra;
        logic [2:0] rb;
        logic       oe;
        logic [7:0] exp_a;
        logic [7:0] exp_b;
        logic [7:0] exp_o;
        logic       exp_v;
    } vec_t;

    logic clk;
    logic reset;

    register_file_8x8_if #(.WIDTH(8), .ADDR_W(3)) bus ();

    register_file_8x8 dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    vec_t vecs[$];
    int   n_vec;
    int   n_bad;

    task automatic add(input logic r, input logic we, input logic [2:0] wa,
                       input logic [7:0] d, input logic re, input logic [2:0] ra,
                       input logic [2:0] rb, input logic oe, input logic [7:0] ea,
                       input logic [7:0] eb, input logic [7:0] eo, input logic ev);
        vec_t v;
        v.rst = r;  v.we = we; v.wa = wa; v.din = d;
        v.re = re;  v.ra = ra; v.rb = rb; v.oe = oe;
        v.exp_a = ea; v.exp_b = eb; v.exp_o = eo; v.exp_v = ev;
        vecs.push_back(v);
    endtask

    // Drive one record, clock one edge, check outputs #1 after the edge.
    task automatic apply(input vec_t v, input string tag);
        reset             = v.rst;
        bus.write_enable  = v.we;
        bus.write_addr    = v.wa;
        bus.from_mux      = v.din;
        bus.read_enable   = v.re;
        bus.read_a_addr   = v.ra;
        bus.read_b_addr   = v.rb;
        bus.output_enable = v.oe;
        @(posedge clk);
        #1;
        n_vec++;
        if (bus.read_a_data !== v.exp_a) begin
            n_bad++;
            $display("FAIL %s read_a_data: got %h want %h", tag, bus.read_a_data, v.exp_a);
        end
        if (bus.read_b_data !== v.exp_b) begin
            n_bad++;
            $display("FAIL %s read_b_data: got %h want %h", tag, bus.read_b_data, v.exp_b);
        end
        if (bus.output_data !== v.exp_o) begin
            n_bad++;
            $display("FAIL %s output_data: got %h want %h", tag, bus.output_data, v.exp_o);
        end
        if (bus.read_valid !== v.exp_v) begin
            n_bad++;
            $display("FAIL %s read_valid: got %b want %b", tag, bus.read_valid, v.exp_v);
        end
    endtask

    initial begin
        vec_t h;
        n_vec = 0;
        n_bad = 0;

        // Reset held two edges with every command active: all discarded.
        add(1, 1, 3'd0, 8'hFF, 1, 3'd0, 3'd0, 1, 8'h00, 8'h00, 8'h00, 0);
        add(1, 1, 3'd7, 8'hFF, 1, 3'd7, 3'd7, 1, 8'h00, 8'h00, 8'h00, 0);
        for (int i = 0; i < 8; i++)
            add(0, 0, 3'd0, 8'h00, 1, 3'(i), 3'(7 - i), 0, 8'h00, 8'h00, 8'h00, 1);

        // Basic write then read, read_valid pulses for one cycle only.
        add(0, 1, 3'd3, 8'hA5, 0, 3'd0, 3'd0, 0, 8'h00, 8'h00, 8'h00, 0);
        add(0, 1, 3'd5, 8'h3C, 0, 3'd0, 3'd0, 0, 8'h00, 8'h00, 8'h00, 0);
        add(0, 0, 3'd0, 8'h00, 1, 3'd3, 3'd5, 0, 8'hA5, 8'h3C, 8'h00, 1);
        add(0, 0, 3'd0, 8'h00, 0, 3'd0, 3'd0, 0, 8'hA5, 8'h3C, 8'h00, 0);

        // Same-edge write+read of one address on both ports.
        add(0, 1, 3'd2, 8'h5A, 1, 3'd2, 3'd2, 0, 8'h5A, 8'h5A, 8'h00, 1);
        add(0, 0, 3'd0, 8'h00, 1, 3'd2, 3'd2, 0, 8'h5A, 8'h5A, 8'h00, 1);
        add(0, 0, 3'd0, 8'h00, 0, 3'd0, 3'd0, 0, 8'h5A, 8'h5A, 8'h00, 0);

        // Output word loads from port A source and holds across writes.
        add(0, 0, 3'd0, 8'h00, 0, 3'd3, 3'd0, 1, 8'h5A, 8'h5A, 8'hA5, 0);
        for (int i = 0; i < 10; i++)
            add(0, 1, 3'd3, 8'(8'h60 + i), 0, 3'd3, 3'd0, 0, 8'h5A, 8'h5A, 8'hA5, 0);
        add(0, 0, 3'd0, 8'h00, 0, 3'd3, 3'd0, 1, 8'h5A, 8'h5A, 8'h69, 0);
        add(0, 1, 3'd4, 8'hC3, 0, 3'd4, 3'd0, 1, 8'h5A, 8'h5A, 8'hC3, 0);

        // Fill all registers, then back-to-back reads in reverse order.
        for (int i = 0; i < 8; i++)
            add(0, 1, 3'(i), 8'(8'h10 + i), 0, 3'd0, 3'd0, 0, 8'h5A, 8'h5A, 8'hC3, 0);
        for (int k = 0; k < 8; k++)
            add(0, 0, 3'd0, 8'h00, 1, 3'(7 - k), 3'(k), 0,
                8'(8'h17 - k), 8'(8'h10 + k), 8'hC3, 1);

        // Bypass applies per port: B hits the write, A does not.
        add(0, 1, 3'd6, 8'hEE, 1, 3'd1, 3'd6, 0, 8'h11, 8'hEE, 8'hC3, 1);
        add(0, 0, 3'd0, 8'h00, 0, 3'd0, 3'd0, 0, 8'h11, 8'hEE, 8'hC3, 0);

        foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

        // X on every disabled port must leave state untouched.
        h.rst = 0; h.we = 0; h.wa = 3'bxxx; h.din = 8'hxx;
        h.re = 0; h.ra = 3'bxxx; h.rb = 3'bxxx; h.oe = 0;
        h.exp_a = 8'h11; h.exp_b = 8'hEE; h.exp_o = 8'hC3; h.exp_v = 0;
        apply(h, "x_idle");
        h.wa = 3'd0; h.din = 8'h00; h.re = 1; h.ra = 3'd6; h.rb = 3'd4;
        h.exp_a = 8'hEE; h.exp_b = 8'h14; h.exp_v = 1;
        apply(h, "x_after");

        // Read launched, then reset on the following edge clears it.
        h.re = 1; h.ra = 3'd3; h.rb = 3'd3;
        h.exp_a = 8'h13; h.exp_b = 8'h13; h.exp_o = 8'hC3; h.exp_v = 1;
        apply(h, "rst_launch");
        h.rst = 1; h.we = 1; h.wa = 3'd3; h.din = 8'hFF; h.oe = 1;
        h.exp_a = 8'h00; h.exp_b = 8'h00; h.exp_o = 8'h00; h.exp_v = 0;
        apply(h, "rst_clear");
        h.rst = 0; h.we = 0; h.oe = 0; h.rb = 3'd4; h.exp_v = 1;
        apply(h, "rst_after");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
